// File: rtl/seg_scan_driver.sv
// Four-digit 7-segment scan driver for the Basys3 display.
// Patterns arrive through a load strobe into shadow registers and are
// committed to the active set only when the scan wraps from digit 3 to 0,
// so a frame is never drawn with a mix of old and new data.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 249999,
    parameter int unsigned BLINK_DIV   = 24999999
) (
    input  logic        basys_clk,
    input  logic        reset_n,
    input  logic [27:0] digit_seg,
    input  logic [3:0]  digit_dp,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  blink_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_start,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DWELL_W = $clog2(REFRESH_DIV + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(REFRESH_DIV);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               pending_q, pending_d;

    logic [27:0] shadow_seg_q, shadow_seg_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic [3:0]  shadow_en_q, shadow_en_d;
    logic [3:0]  shadow_blink_q, shadow_blink_d;

    logic [27:0] active_seg_q, active_seg_d;
    logic [3:0]  active_dp_q, active_dp_d;
    logic [3:0]  active_en_q, active_en_d;
    logic [3:0]  active_blink_q, active_blink_d;

    logic        load_ack_q, load_ack_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;

    logic dwell_done;
    logic frame_wrap;
    logic commit;

    logic [6:0] sel_seg;
    logic       sel_dp;
    logic       sel_en;
    logic       sel_blink;

    assign dwell_done = (dwell_q == DWELL_MAX);
    assign frame_wrap = dwell_done && (idx_q == 2'd3);
    assign commit     = frame_wrap && pending_q;

    // Dwell timer steps the scan index; blink timer toggles the blink phase.
    always_comb begin
        dwell_d       = dwell_q + DWELL_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (dwell_done) begin
            dwell_d = '0;
            idx_d   = idx_q + 2'd1;
        end
        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Load captures into shadow; commit copies the pre-edge shadow to active.
    // A load coinciding with a commit keeps pending set for the next frame.
    always_comb begin
        shadow_seg_d   = shadow_seg_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_en_d    = shadow_en_q;
        shadow_blink_d = shadow_blink_q;
        active_seg_d   = active_seg_q;
        active_dp_d    = active_dp_q;
        active_en_d    = active_en_q;
        active_blink_d = active_blink_q;
        pending_d      = pending_q;
        load_ack_d     = 1'b0;
        if (commit) begin
            active_seg_d   = shadow_seg_q;
            active_dp_d    = shadow_dp_q;
            active_en_d    = shadow_en_q;
            active_blink_d = shadow_blink_q;
            pending_d      = 1'b0;
            load_ack_d     = 1'b1;
        end
        if (load) begin
            shadow_seg_d   = digit_seg;
            shadow_dp_d    = digit_dp;
            shadow_en_d    = digit_en;
            shadow_blink_d = blink_en;
            pending_d      = 1'b1;
        end
    end

    // Pick the current digit and decide whether it is lit or blanked.
    always_comb begin
        sel_seg   = 7'h7F;
        sel_dp    = 1'b1;
        sel_en    = 1'b0;
        sel_blink = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (idx_q == 2'(i)) begin
                sel_seg   = active_seg_q[7*i +: 7];
                sel_dp    = active_dp_q[i];
                sel_en    = active_en_q[i];
                sel_blink = active_blink_q[i];
            end
        end
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (sel_en && !(sel_blink && blink_phase_q)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = sel_seg;
            dp_d  = sel_dp;
        end
    end

    // State and registered pin drivers; reset leaves every digit blank.
    always_ff @(posedge basys_clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell_q        <= '0;
            idx_q          <= 2'd0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            pending_q      <= 1'b0;
            shadow_seg_q   <= 28'hFFFFFFF;
            shadow_dp_q    <= 4'hF;
            shadow_en_q    <= 4'h0;
            shadow_blink_q <= 4'h0;
            active_seg_q   <= 28'hFFFFFFF;
            active_dp_q    <= 4'hF;
            active_en_q    <= 4'h0;
            active_blink_q <= 4'h0;
            load_ack_q     <= 1'b0;
            an_q           <= 4'b1111;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
        end else begin
            dwell_q        <= dwell_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            pending_q      <= pending_d;
            shadow_seg_q   <= shadow_seg_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            shadow_blink_q <= shadow_blink_d;
            active_seg_q   <= active_seg_d;
            active_dp_q    <= active_dp_d;
            active_en_q    <= active_en_d;
            active_blink_q <= active_blink_d;
            load_ack_q     <= load_ack_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    assign load_ack    = load_ack_q;
    assign frame_start = frame_wrap;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a 4-cycle dwell and 16-cycle
// blink half-period, giving a 16-cycle frame. Edge numbers count rising
// clock edges after reset release; outputs are sampled 1 ns after each edge.
module tb_seg_scan_driver;

    logic        clk;
    logic        resetN;
    logic [27:0] digitSeg;
    logic [3:0]  digitDp;
    logic [3:0]  digitEn;
    logic [3:0]  blinkEn;
    logic        load;
    logic        loadAck;
    logic        frameStart;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int passCount;
    int checkCount;
    int edgeNum;
    int ackCount;

    typedef struct {
        int         edgeAt;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        logic       expDp;
        logic       expAck;
        logic       expFrame;
    } vec_t;

    vec_t vecs [13];

    localparam logic [27:0] DATA_T2 = {7'h24, 7'h79, 7'h30, 7'h12};
    localparam logic [27:0] DATA_A  = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] DATA_B  = {7'h00, 7'h19, 7'h02, 7'h78};

    seg_scan_driver #(
        .REFRESH_DIV(3),
        .BLINK_DIV(15)
    ) dut (
        .basys_clk  (clk),
        .reset_n    (resetN),
        .digit_seg  (digitSeg),
        .digit_dp   (digitDp),
        .digit_en   (digitEn),
        .blink_en   (blinkEn),
        .load       (load),
        .load_ack   (loadAck),
        .frame_start(frameStart),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and keep the pass/total tallies
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNum, act, exp);
        end
    endtask

    // Advance one clock edge, track acks and check that at most one anode is low
    task automatic step();
        @(posedge clk);
        #1;
        edgeNum++;
        if (loadAck === 1'b1) ackCount++;
        checkOutput("one_anode", ($countones(~an) <= 1) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic runTo(input int target);
        while (edgeNum < target) step();
    endtask

    task automatic doReset();
        resetN   = 1'b0;
        load     = 1'b0;
        digitSeg = 28'h0;
        digitDp  = 4'h0;
        digitEn  = 4'h0;
        blinkEn  = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN   = 1'b1;
        edgeNum  = 0;
        ackCount = 0;
    endtask

    // Present data with load so that it is captured at edge loadEdge
    task automatic applyStimulus(input int loadEdge, input logic [27:0] segs, input logic [3:0] dps,
                                 input logic [3:0] ens, input logic [3:0] blinks);
        runTo(loadEdge - 1);
        digitSeg = segs;
        digitDp  = dps;
        digitEn  = ens;
        digitBlinkSet(blinks);
        load     = 1'b1;
        step();
        load     = 1'b0;
        digitSeg = 28'h5A5A5A5;
        digitEn  = 4'h0;
    endtask

    task automatic digitBlinkSet(input logic [3:0] blinks);
        blinkEn = blinks;
    endtask

    task automatic checkDigit(input string name, input logic [3:0] expAn, input logic [6:0] expSeg, input logic expDp);
        checkOutput({name, "_an"}, {28'h0, an}, {28'h0, expAn});
        checkOutput({name, "_seg"}, {25'h0, seg}, {25'h0, expSeg});
        checkOutput({name, "_dp"}, {31'h0, dp}, {31'h0, expDp});
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        edgeNum    = 0;
        ackCount   = 0;

        vecs[0]  = '{10, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{14, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{15, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{16, 4'b1111, 7'h7F, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{17, 4'b1110, 7'h12, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{20, 4'b1110, 7'h12, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{21, 4'b1101, 7'h30, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{24, 4'b1101, 7'h30, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{25, 4'b1011, 7'h79, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{28, 4'b1011, 7'h79, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{29, 4'b0111, 7'h24, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{31, 4'b0111, 7'h24, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{33, 4'b1110, 7'h12, 1'b1, 1'b0, 1'b0};

        // Reset state, sampled while reset is held
        resetN = 1'b0;
        load   = 1'b0;
        #12;
        checkDigit("reset", 4'b1111, 7'h7F, 1'b1);
        checkOutput("reset_ack", {31'h0, loadAck}, 32'd0);
        checkOutput("reset_frame", {31'h0, frameStart}, 32'd0);

        // Idle after reset: blank display, frame pulse every 16 edges, no ack
        doReset();
        for (int n = 1; n <= 64; n++) begin
            step();
            checkDigit("idle", 4'b1111, 7'h7F, 1'b1);
            checkOutput("idle_frame", {31'h0, frameStart}, (n % 16 == 15) ? 32'd1 : 32'd0);
        end
        checkOutput("idle_acks", ackCount, 0);

        // Single load at edge 5, commit on the next wrap, full scan sequence
        doReset();
        applyStimulus(5, DATA_T2, 4'b1011, 4'hF, 4'h0);
        for (int v = 0; v < 13; v++) begin
            runTo(vecs[v].edgeAt);
            checkDigit($sformatf("t2_e%0d", vecs[v].edgeAt), vecs[v].expAn, vecs[v].expSeg, vecs[v].expDp);
            checkOutput("t2_ack", {31'h0, loadAck}, {31'h0, vecs[v].expAck});
            checkOutput("t2_frame", {31'h0, frameStart}, {31'h0, vecs[v].expFrame});
        end
        runTo(48);
        checkOutput("t2_acks", ackCount, 1);

        // Two loads in one frame: only the second is shown, one ack
        doReset();
        applyStimulus(5, DATA_A, 4'hF, 4'hF, 4'h0);
        applyStimulus(9, DATA_B, 4'hF, 4'hF, 4'h0);
        runTo(17);
        checkDigit("t3_d0", 4'b1110, 7'h78, 1'b1);
        runTo(21);
        checkDigit("t3_d1", 4'b1101, 7'h02, 1'b1);
        runTo(25);
        checkDigit("t3_d2", 4'b1011, 7'h19, 1'b1);
        runTo(29);
        checkDigit("t3_d3", 4'b0111, 7'h00, 1'b1);
        runTo(40);
        checkOutput("t3_acks", ackCount, 1);

        // Load in the wrap cycle while pending: old data now, new data next frame
        doReset();
        applyStimulus(5, DATA_A, 4'hF, 4'hF, 4'h0);
        applyStimulus(16, DATA_B, 4'hF, 4'hF, 4'h0);
        checkOutput("t4_ack1", {31'h0, loadAck}, 32'd1);
        runTo(17);
        checkDigit("t4_old", 4'b1110, 7'h21, 1'b1);
        runTo(31);
        checkOutput("t4_acks_mid", ackCount, 1);
        runTo(32);
        checkOutput("t4_ack2", {31'h0, loadAck}, 32'd1);
        runTo(33);
        checkDigit("t4_new", 4'b1110, 7'h78, 1'b1);
        runTo(40);
        checkOutput("t4_acks", ackCount, 2);

        // Blink on digit 0 only; phase is 1 during edges 16..31, 48..63
        doReset();
        applyStimulus(5, DATA_A, 4'hF, 4'hF, 4'b0001);
        runTo(17);
        checkDigit("t5_off1", 4'b1111, 7'h7F, 1'b1);
        runTo(21);
        checkDigit("t5_d1a", 4'b1101, 7'h46, 1'b1);
        runTo(33);
        checkDigit("t5_on", 4'b1110, 7'h21, 1'b1);
        runTo(36);
        checkDigit("t5_on_end", 4'b1110, 7'h21, 1'b1);
        runTo(37);
        checkDigit("t5_d1b", 4'b1101, 7'h46, 1'b1);
        runTo(49);
        checkDigit("t5_off2", 4'b1111, 7'h7F, 1'b1);
        runTo(53);
        checkDigit("t5_d1c", 4'b1101, 7'h46, 1'b1);
        runTo(65);
        checkDigit("t5_on2", 4'b1110, 7'h21, 1'b1);

        // Reset mid-frame with a pending load: blank at once, no ack afterwards
        doReset();
        applyStimulus(5, DATA_A, 4'hF, 4'hF, 4'h0);
        applyStimulus(20, DATA_B, 4'hF, 4'hF, 4'h0);
        runTo(22);
        checkDigit("t6_pre", 4'b1101, 7'h46, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        checkDigit("t6_async", 4'b1111, 7'h7F, 1'b1);
        checkOutput("t6_async_ack", {31'h0, loadAck}, 32'd0);
        @(negedge clk);
        resetN   = 1'b1;
        edgeNum  = 0;
        ackCount = 0;
        for (int n = 1; n <= 40; n++) begin
            step();
            checkOutput("t6_blank_an", {28'h0, an}, 32'hF);
            checkOutput("t6_no_ack", {31'h0, loadAck}, 32'd0);
        end
        checkOutput("t6_seg", {25'h0, seg}, 32'h7F);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
